fetch: RTL and testbench
========================

FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter ADDRESS_BITS, default 5, SHALL set the operand address field width of each instruction byte.
REQ-002 Parameter INSTR_BITS, default 3, SHALL set the opcode field width; VALUE_BITS = INSTR_BITS + ADDRESS_BITS (8).
REQ-003 Parameter PC_BITS, default 8, SHALL set the program counter and memory address width.
REQ-004 Parameter TIMEOUT, default 15, SHALL set the maximum number of cycles spent in WAIT, range 1..255.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  begin fetching at start_addr; sampled only in IDLE.
REQ-008 start_addr  in  PC_BITS  first fetch address.
REQ-009 mem_rd  out  1  one-cycle program-memory read strobe.
REQ-010 mem_addr  out  PC_BITS  read address, equal to pc.
REQ-011 mem_valid  in  1  read data valid; accepted only in WAIT.
REQ-012 mem_data  in  VALUE_BITS  read data.
REQ-013 ready  in  1  downstream controller can accept an instruction.
REQ-014 enable  out  1  instruction-valid strobe to the controller.
REQ-015 value  out  VALUE_BITS  instruction byte: opcode in bits [VALUE_BITS-1:ADDRESS_BITS], operand address in bits [ADDRESS_BITS-1:0].
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle pulse on halt.
REQ-018 error  out  1  sticky timeout flag.

Function
REQ-019 The FSM SHALL have the states IDLE, REQ, WAIT and ISSUE, with all state registers updated on the rising edge of clk.
REQ-020 IDLE: on start=1, the block SHALL load pc<=start_addr, clear error and enter REQ; otherwise it SHALL remain in IDLE.
REQ-021 REQ: mem_rd SHALL be 1 for exactly this one cycle with mem_addr=pc, the timeout counter SHALL clear, and the next state SHALL be WAIT.
REQ-022 WAIT: on mem_valid=1, the block SHALL capture value<=mem_data and enter ISSUE, unless mem_data[VALUE_BITS-1:ADDRESS_BITS]==0 (HALT).
REQ-023 WAIT with HALT data: value SHALL be left unchanged, done SHALL pulse high for the following cycle, and the next state SHALL be IDLE.
REQ-024 WAIT: the counter SHALL increment each cycle in which mem_valid=0; when it reaches TIMEOUT, the block SHALL set error<=1 and enter IDLE with no done pulse.
REQ-025 ISSUE: enable SHALL equal ready, decoded combinationally from state.
REQ-026 ISSUE with ready=1: the block SHALL set pc<=pc+1 and enter REQ.
REQ-027 ISSUE with ready=0: the block SHALL hold state, value and pc unchanged indefinitely.
REQ-028 The pc increment SHALL be modulo 2^PC_BITS, so 255 wraps to 0 with no flag.
REQ-029 mem_valid SHALL be ignored in IDLE, REQ and ISSUE.
REQ-030 start SHALL be ignored while busy=1.
REQ-031 Mid-fetch memory completion SHALL not be cancelled; the fetch is abandoned only by timeout or reset.
REQ-032 Latency: with start at cycle 0, mem_rd SHALL be high in cycle 1; mem_valid in cycle k SHALL produce enable in cycle k+1 when ready=1.
REQ-033 Best-case throughput SHALL be one instruction per 3 cycles.
REQ-034 enable SHALL never be high for two consecutive cycles.
REQ-035 value SHALL remain stable for as long as enable may be asserted.

Reset
REQ-036 rst_n=0 SHALL, immediately and independent of clk, force state=IDLE, pc=0, value=0, counter=0, and error, done, mem_rd and enable to 0.
REQ-037 Reset asserted in any state, including mid-WAIT or ISSUE with ready=0, SHALL discard the pending fetch, and SHALL not pulse done or set error.
REQ-038 After rst_n deasserts, the block SHALL sit in IDLE until start.

Verification
REQ-039 Basic fetch: start_addr=8'h10, start pulse, memory returns 8'h25 two cycles after mem_rd, ready=1 -> mem_rd at cycle 1 with mem_addr=8'h10, enable one cycle with value=8'h25, next mem_rd with mem_addr=8'h11.
REQ-040 Backpressure: ready=0 for 5 cycles in ISSUE with value=8'h43 -> enable=0 and value=8'h43 held for those cycles; enable=1 in the cycle ready rises, then the next mem_rd.
REQ-041 Halt: memory returns 8'h1F -> no enable, done pulses for one cycle, busy falls, and a later start restarts from the new start_addr.
REQ-042 Timeout: mem_valid never asserted -> error=1 and busy=0 exactly TIMEOUT cycles after WAIT entry; a stray mem_valid afterwards is ignored; the next start clears error.
REQ-043 Wrap: start_addr=8'hFF, non-halt data 8'h41 -> the next mem_addr is 8'h00.
REQ-044 Reset mid-operation: rst_n low during WAIT, then mem_valid with 8'h41 -> all outputs 0 asynchronously and no enable after release.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch unit bus bundle: start/status handshake, program-memory read port and
// the instruction hand-off to the downstream controller.
interface fetch_if #(
  parameter int PC_BITS    = 8,
  parameter int VALUE_BITS = 8
);
  logic                  start;
  logic [PC_BITS-1:0]    start_addr;
  logic                  mem_rd;
  logic [PC_BITS-1:0]    mem_addr;
  logic                  mem_valid;
  logic [VALUE_BITS-1:0] mem_data;
  logic                  ready;
  logic                  enable;
  logic [VALUE_BITS-1:0] value;
  logic                  busy;
  logic                  done;
  logic                  error;

  modport master (
    input  start, start_addr, mem_valid, mem_data, ready,
    output mem_rd, mem_addr, enable, value, busy, done, error
  );

  modport slave (
    output start, start_addr, mem_valid, mem_data, ready,
    input  mem_rd, mem_addr, enable, value, busy, done, error
  );
endinterface

// File: rtl/fetch.sv
// Instruction fetch FSM: reads one byte per instruction from program memory,
// stops on a HALT opcode (zero) or a read timeout, and hands bytes downstream.
module fetch #(
  parameter int ADDRESS_BITS = 5,
  parameter int INSTR_BITS   = 3,
  parameter int PC_BITS      = 8,
  parameter int TIMEOUT      = 15
) (
  input logic    clk,
  input logic    rst_n,
  fetch_if.master bus
);
  localparam int VALUE_BITS = INSTR_BITS + ADDRESS_BITS;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_ISSUE = 2'd3;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  logic [1:0]            state_q, state_d;
  logic [PC_BITS-1:0]    pc_q, pc_d;
  logic [VALUE_BITS-1:0] value_q, value_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;
  logic [7:0]            cnt_inc;

  function automatic logic is_halt(input logic [VALUE_BITS-1:0] d);
    return (d[VALUE_BITS-1:ADDRESS_BITS] == {INSTR_BITS{1'b0}});
  endfunction

  assign cnt_inc = cnt_q + 8'd1;

  // Next-state and datapath decode
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    value_d = value_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          pc_d    = bus.start_addr;
          err_d   = 1'b0;
          state_d = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        cnt_d   = 8'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.mem_valid) begin
          if (is_halt(bus.mem_data)) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            value_d = bus.mem_data;
            state_d = S_ISSUE;
          end
        end else if (cnt_inc == TIMEOUT_C) begin
          // Give up: the WAIT state has now lasted TIMEOUT cycles.
          cnt_d   = cnt_inc;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d   = cnt_inc;
        end
      end
      S_ISSUE: begin
        if (bus.ready) begin
          pc_d    = pc_q + PC_BITS'(1);
          state_d = S_REQ;
        end else begin
          state_d = S_ISSUE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= {PC_BITS{1'b0}};
      value_q <= {VALUE_BITS{1'b0}};
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      value_q <= value_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign bus.mem_rd   = (state_q == S_REQ);
  assign bus.mem_addr = pc_q;
  assign bus.enable   = (state_q == S_ISSUE) && bus.ready;
  assign bus.value    = value_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = done_q;
  assign bus.error    = err_q;
endmodule

// File: tb/tb_fetch.sv
// Directed self-checking bench for the fetch unit.
module tb_fetch;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  fetch_if #(.PC_BITS(8), .VALUE_BITS(8)) bus ();

  fetch #(
    .ADDRESS_BITS(5),
    .INSTR_BITS  (3),
    .PC_BITS     (8),
    .TIMEOUT     (15)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.start_addr = 8'h00;
    bus.mem_valid  = 1'b0;
    bus.mem_data   = 8'h00;
    bus.ready      = 1'b0;

    // Reset state, before any clock edge
    #3;
    chk("rst_busy",   32'(bus.busy),     32'h0);
    chk("rst_mem_rd", 32'(bus.mem_rd),   32'h0);
    chk("rst_addr",   32'(bus.mem_addr), 32'h0);
    chk("rst_value",  32'(bus.value),    32'h0);
    chk("rst_enable", 32'(bus.enable),   32'h0);
    chk("rst_done",   32'(bus.done),     32'h0);
    chk("rst_error",  32'(bus.error),    32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_after_rst", 32'(bus.busy), 32'h0);

    // Basic fetch from 0x10
    bus.start      = 1'b1;
    bus.start_addr = 8'h10;
    bus.ready      = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("basic_rd",   32'(bus.mem_rd),   32'h1);
    chk("basic_addr", 32'(bus.mem_addr), 32'h10);
    chk("basic_busy", 32'(bus.busy),     32'h1);
    tick();
    chk("basic_rd_once", 32'(bus.mem_rd), 32'h0);
    tick();
    bus.mem_valid = 1'b1;
    bus.mem_data  = 8'h25;
    chk("basic_no_en_wait", 32'(bus.enable), 32'h0);
    tick();
    bus.mem_valid = 1'b0;
    chk("basic_enable", 32'(bus.enable), 32'h1);
    chk("basic_value",  32'(bus.value),  32'h25);
    tick();
    chk("basic_rd2",    32'(bus.mem_rd),   32'h1);
    chk("basic_addr2",  32'(bus.mem_addr), 32'h11);
    chk("basic_en_off", 32'(bus.enable),   32'h0);

    // Backpressure with 0x43; stray memory data in ISSUE must be ignored
    tick();
    bus.mem_valid = 1'b1;
    bus.mem_data  = 8'h43;
    bus.ready     = 1'b0;
    tick();
    bus.mem_data = 8'h77;
    for (int i = 0; i < 5; i++) begin
      chk("bp_enable", 32'(bus.enable), 32'h0);
      chk("bp_value",  32'(bus.value),  32'h43);
      chk("bp_busy",   32'(bus.busy),   32'h1);
      tick();
    end
    bus.mem_valid = 1'b0;
    bus.ready     = 1'b1;
    #1;
    chk("bp_enable_rise", 32'(bus.enable), 32'h1);
    chk("bp_value_hold",  32'(bus.value),  32'h43);
    tick();
    chk("bp_next_rd",   32'(bus.mem_rd),   32'h1);
    chk("bp_next_addr", 32'(bus.mem_addr), 32'h12);
    chk("bp_en_single", 32'(bus.enable),   32'h0);

    // Halt opcode 0x1F
    tick();
    bus.mem_valid = 1'b1;
    bus.mem_data  = 8'h1F;
    tick();
    bus.mem_valid = 1'b0;
    chk("halt_done",   32'(bus.done),   32'h1);
    chk("halt_busy",   32'(bus.busy),   32'h0);
    chk("halt_enable", 32'(bus.enable), 32'h0);
    chk("halt_value",  32'(bus.value),  32'h43);
    tick();
    chk("halt_done_pulse", 32'(bus.done), 32'h0);
    bus.start      = 1'b1;
    bus.start_addr = 8'h80;
    tick();
    bus.start = 1'b0;
    chk("restart_rd",   32'(bus.mem_rd),   32'h1);
    chk("restart_addr", 32'(bus.mem_addr), 32'h80);

    // Timeout: no mem_valid; start while busy must be ignored
    tick();
    for (int i = 0; i < 15; i++) begin
      bus.start      = (i == 0);
      bus.start_addr = 8'h33;
      chk("to_busy",  32'(bus.busy),     32'h1);
      chk("to_error", 32'(bus.error),    32'h0);
      chk("to_addr",  32'(bus.mem_addr), 32'h80);
      tick();
    end
    bus.start = 1'b0;
    chk("to_busy_fall", 32'(bus.busy),  32'h0);
    chk("to_error_set", 32'(bus.error), 32'h1);
    chk("to_no_done",   32'(bus.done),  32'h0);
    bus.mem_valid = 1'b1;
    bus.mem_data  = 8'h41;
    tick();
    bus.mem_valid = 1'b0;
    chk("stray_busy",   32'(bus.busy),   32'h0);
    chk("stray_enable", 32'(bus.enable), 32'h0);
    chk("stray_value",  32'(bus.value),  32'h43);
    chk("stray_error",  32'(bus.error),  32'h1);

    // Next start clears error; also sets up the wrap case at 0xFF
    bus.start      = 1'b1;
    bus.start_addr = 8'hFF;
    tick();
    bus.start = 1'b0;
    chk("clr_error", 32'(bus.error),    32'h0);
    chk("wrap_addr", 32'(bus.mem_addr), 32'hFF);
    tick();
    bus.mem_valid = 1'b1;
    bus.mem_data  = 8'h41;
    tick();
    bus.mem_valid = 1'b0;
    chk("wrap_enable", 32'(bus.enable), 32'h1);
    chk("wrap_value",  32'(bus.value),  32'h41);
    tick();
    chk("wrap_rd",       32'(bus.mem_rd),   32'h1);
    chk("wrap_addr_new", 32'(bus.mem_addr), 32'h00);

    // Asynchronous reset during WAIT
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy",   32'(bus.busy),     32'h0);
    chk("arst_addr",   32'(bus.mem_addr), 32'h0);
    chk("arst_value",  32'(bus.value),    32'h0);
    chk("arst_rd",     32'(bus.mem_rd),   32'h0);
    chk("arst_enable", 32'(bus.enable),   32'h0);
    chk("arst_done",   32'(bus.done),     32'h0);
    chk("arst_error",  32'(bus.error),    32'h0);
    bus.mem_valid = 1'b1;
    bus.mem_data  = 8'h41;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_enable", 32'(bus.enable), 32'h0);
    chk("post_rst_busy",   32'(bus.busy),   32'h0);
    chk("post_rst_value",  32'(bus.value),  32'h0);
    bus.mem_valid = 1'b0;
    tick();
    chk("post_rst_done",  32'(bus.done),  32'h0);
    chk("post_rst_error", 32'(bus.error), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
